iir_notch_cascade_tdm: RTL and testbench
========================================

// Module: iir_notch_cascade_tdm
// PURPOSE
//  Parametrised N-stage cascade of biquad IIR notch sections sharing ONE time-multiplexed biquad datapath.
//  Successor to the fixed two-stage notch chain: stage count, widths and coefficients are runtime/compile-time
//  configurable; adds valid handshake, per-stage bypass, coefficient write port, rounding/saturation and status.
//  Sits in the DFE chain after decimation, on the 18 MHz clock; input sample rate <= clk/(NUM_STAGES+2).
// PARAMETERS
//  DATA_WIDTH  16  sample width, signed two's complement
//  COEF_WIDTH  16  coefficient width, signed, Q(COEF_WIDTH-COEF_FRAC).COEF_FRAC
//  COEF_FRAC   14  coefficient fractional bits (1.0 = 16384)
//  NUM_STAGES   4  number of cascaded biquads, 1..8
// PORTS
//  clk         in   1                      system clock
//  rst_n       in   1                      asynchronous active-low reset
//  x_in        in   DATA_WIDTH             input sample, sampled when x_valid=1
//  x_valid     in   1                      input strobe
//  x_ready     out  1                      1 when FSM in IDLE
//  y_out       out  DATA_WIDTH             filtered sample
//  y_valid     out  1                      1-cycle strobe, y_out valid
//  bypass      in   NUM_STAGES             bit s=1: stage s passes input unchanged, state not updated
//  flush       in   1                      synchronous clear of all delay-line state
//  coef_we     in   1                      coefficient write strobe
//  coef_addr   in   $clog2(5*NUM_STAGES)   stage*5 + {0:b0,1:b1,2:b2,3:a1,4:a2}
//  coef_wdata  in   COEF_WIDTH             coefficient value
//  coef_ready  out  1                      1 when FSM in IDLE; writes accepted only then
//  sat_flag    out  1                      sticky: any stage saturated; cleared by flush
//  drop_flag   out  1                      sticky: x_valid seen while x_ready=0; cleared by flush
// BEHAVIOUR
//  Reset: y_out=0, y_valid=0, sat_flag=0, drop_flag=0, all x1/x2/y1/y2=0, FSM=IDLE,
//   coefs: b0=1<<COEF_FRAC, b1=b2=a1=a2=0 (every stage passthrough).
//  FSM: IDLE -(x_valid)-> RUN(stage 0..NUM_STAGES-1, one stage/cycle) -> DONE -> IDLE.
//   IDLE: latch x_in into stage pipe reg. RUN: compute stage s, feed result to s+1. DONE: y_out<=last result, y_valid=1.
//  Latency: x_valid at cycle t -> y_valid at t+NUM_STAGES+1; x_ready low t+1..t+NUM_STAGES+1.
//  Stage math (direct form I): acc = b0*x + b1*x1 + b2*x2 - a1*y1 - a2*y2,
//   acc width DATA_WIDTH+COEF_WIDTH+3; y = (acc + 2^(COEF_FRAC-1)) >>> COEF_FRAC (round half up);
//   saturate to [-2^(DW-1), 2^(DW-1)-1], set sat_flag on clip; state update x2<=x1,x1<=x, y2<=y1,y1<=y(saturated).
//  Bypass: bypass bit sampled at the stage's RUN cycle; bypassed stage output = input, its state held.
//  Drop: x_valid while x_ready=0 is ignored, sets drop_flag; running computation unaffected.
//  coef_we while coef_ready=0: write ignored (not queued). coef_we and x_valid same IDLE cycle: both accepted,
//   new coefficient used for that sample.
//  flush: clears state regs and sticky flags next edge; in RUN/DONE it aborts to IDLE, no y_valid issued.
//  Reset mid-operation: async, all of the above reset values immediately; coefficients return to passthrough.
// CONFIGURATION
//  IIR_CASCADE_SATCNT_EN defined: adds output sat_count [15:0], counts saturation events (saturating at 16'hFFFF),
//   reset 0, cleared by flush. Undefined: port and counter absent; sat_flag behaviour unchanged.
// TESTING
//  1 After reset, x_in=1000 x_valid pulse -> y_valid exactly NUM_STAGES+1 cycles later, y_out=1000 (passthrough).
//  2 Stage0 b0=8192 (0.5), others reset; x_in=-3 -> y_out=-1 (round half up of -1.5); bypass[0]=1 -> y_out=-3.
//  3 Stage0 b0=b2=16384, b1=-2*cos(w0) notch at 2.4 MHz/18 MHz, a1/a2 r=0.95; 2.4 MHz tone amplitude 8000
//    -> settled |y_out|<200; 1 MHz tone -> amplitude within 5% of 8000; compare to bit-true C model, 0 mismatches.
//  4 b0=32767, x_in=32767 -> y_out=32767, sat_flag=1 (sat_count=1 if IIR_CASCADE_SATCNT_EN); flush -> flags 0.
//  5 Two x_valid pulses 1 cycle apart -> second dropped, drop_flag=1, single y_valid; coef_we during RUN -> no change.
//  6 Assert rst_n=0 during RUN at stage 2 -> outputs 0, x_ready=1 after release, next sample passthrough.

Source files
------------

// File: rtl/iir_notch_cascade_tdm.sv
// rtl/iir_notch_cascade_tdm.sv - N-stage biquad notch cascade on one time-multiplexed datapath (option: IIR_CASCADE_SATCNT_EN adds sat_count)
module iir_notch_cascade_tdm #(
    parameter int DATA_WIDTH = 16,
    parameter int COEF_WIDTH = 16,
    parameter int COEF_FRAC  = 14,
    parameter int NUM_STAGES = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic signed [DATA_WIDTH-1:0]          x_in,
    input  logic                                  x_valid,
    output logic                                  x_ready,
    output logic signed [DATA_WIDTH-1:0]          y_out,
    output logic                                  y_valid,
    input  logic [NUM_STAGES-1:0]                 bypass,
    input  logic                                  flush,
    input  logic                                  coef_we,
    input  logic [$clog2(5*NUM_STAGES)-1:0]       coef_addr,
    input  logic signed [COEF_WIDTH-1:0]          coef_wdata,
    output logic                                  coef_ready,
`ifdef IIR_CASCADE_SATCNT_EN
    output logic [15:0]                           sat_count,
`endif
    output logic                                  sat_flag,
    output logic                                  drop_flag
);
    localparam int AW  = DATA_WIDTH + COEF_WIDTH + 3;
    localparam int SW  = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam int CAW = $clog2(5*NUM_STAGES);
    localparam logic signed [AW-1:0] RND  = {{(AW-COEF_FRAC){1'b0}}, 1'b1, {(COEF_FRAC-1){1'b0}}};
    localparam logic signed [AW-1:0] AMAX = {{(AW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [AW-1:0] AMIN = {{(AW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [DATA_WIDTH-1:0] YMAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] YMIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [COEF_WIDTH-1:0] ONE  = {{(COEF_WIDTH-COEF_FRAC-1){1'b0}}, 1'b1, {COEF_FRAC{1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                       r_state, w_next;
    logic [SW-1:0]                r_stage;
    logic signed [DATA_WIDTH-1:0] r_pipe;
    logic signed [COEF_WIDTH-1:0] r_coef [NUM_STAGES][5];
    logic signed [DATA_WIDTH-1:0] r_x1 [NUM_STAGES];
    logic signed [DATA_WIDTH-1:0] r_x2 [NUM_STAGES];
    logic signed [DATA_WIDTH-1:0] r_y1 [NUM_STAGES];
    logic signed [DATA_WIDTH-1:0] r_y2 [NUM_STAGES];

    logic signed [AW-1:0]         w_acc, w_shift;
    logic signed [DATA_WIDTH-1:0] w_sat_y, w_stage_out;
    logic                         w_byp, w_clip, w_last, w_run, w_idle, w_hi, w_lo;

    // Sign-extend both operands to accumulator width so the product is exact.
    function automatic logic signed [AW-1:0] mul(input logic signed [COEF_WIDTH-1:0] c,
                                                 input logic signed [DATA_WIDTH-1:0] d);
        logic signed [AW-1:0] ce, de;
        ce = {{(AW-COEF_WIDTH){c[COEF_WIDTH-1]}}, c};
        de = {{(AW-DATA_WIDTH){d[DATA_WIDTH-1]}}, d};
        return ce * de;
    endfunction

    assign w_idle      = (r_state == S_IDLE);
    assign w_run       = (r_state == S_RUN);
    assign w_last      = (r_stage == SW'(NUM_STAGES-1));
    assign w_byp       = bypass[r_stage];
    assign x_ready     = w_idle;
    assign coef_ready  = w_idle;

    // Shared biquad: the stage selected by r_stage, rounded half-up then clipped.
    always_comb begin
        w_acc = mul(r_coef[r_stage][0], r_pipe)
              + mul(r_coef[r_stage][1], r_x1[r_stage])
              + mul(r_coef[r_stage][2], r_x2[r_stage])
              - mul(r_coef[r_stage][3], r_y1[r_stage])
              - mul(r_coef[r_stage][4], r_y2[r_stage]);
        w_shift     = (w_acc + RND) >>> COEF_FRAC;
        w_hi        = (w_shift > AMAX);
        w_lo        = (w_shift < AMIN);
        w_sat_y     = w_hi ? YMAX : (w_lo ? YMIN : w_shift[DATA_WIDTH-1:0]);
        w_clip      = w_run && !w_byp && (w_hi || w_lo);
        w_stage_out = w_byp ? r_pipe : w_sat_y;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next state: flush always returns to IDLE and suppresses the pending output.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (x_valid && !flush) w_next = S_RUN;
            S_RUN:   if (flush)             w_next = S_IDLE;
                     else if (w_last)       w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Sample pipe register and stage sequencer; each RUN cycle passes the result on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage <= '0;
            r_pipe  <= '0;
        end else if (w_idle) begin
            r_stage <= '0;
            if (x_valid && !flush) r_pipe <= x_in;
        end else if (w_run) begin
            r_stage <= r_stage + SW'(1);
            r_pipe  <= w_stage_out;
        end
    end

    // Coefficient RAM; writes only land in IDLE, reset restores passthrough.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_STAGES; s++)
                for (int k = 0; k < 5; k++)
                    r_coef[s][k] <= (k == 0) ? ONE : '0;
        end else if (coef_we && w_idle) begin
            for (int s = 0; s < NUM_STAGES; s++)
                for (int k = 0; k < 5; k++)
                    if (coef_addr == CAW'(s*5 + k)) r_coef[s][k] <= coef_wdata;
        end
    end

    // Per-stage delay lines; bypassed stages keep their history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || flush) begin
            for (int s = 0; s < NUM_STAGES; s++) begin
                r_x1[s] <= '0;
                r_x2[s] <= '0;
                r_y1[s] <= '0;
                r_y2[s] <= '0;
            end
        end else if (w_run && !w_byp) begin
            r_x1[r_stage] <= r_pipe;
            r_x2[r_stage] <= r_x1[r_stage];
            r_y1[r_stage] <= w_sat_y;
            r_y2[r_stage] <= r_y1[r_stage];
        end
    end

    // Output register and strobe, loaded as the last stage completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_out   <= '0;
            y_valid <= 1'b0;
        end else begin
            y_valid <= w_run && w_last && !flush;
            if (w_run && w_last && !flush) y_out <= w_stage_out;
        end
    end

    // Sticky status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || flush) begin
            sat_flag  <= 1'b0;
            drop_flag <= 1'b0;
        end else begin
            sat_flag  <= sat_flag  | w_clip;
            drop_flag <= drop_flag | (x_valid && !w_idle);
        end
    end

`ifdef IIR_CASCADE_SATCNT_EN
    // Saturation event counter, pinned at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || flush)                 sat_count <= '0;
        else if (w_clip && sat_count != '1)  sat_count <= sat_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_iir_notch_cascade_tdm.sv
// tb/tb_iir_notch_cascade_tdm.sv - scoreboard bench for iir_notch_cascade_tdm
module tb_iir_notch_cascade_tdm;
    localparam int DW  = 16;
    localparam int CW  = 16;
    localparam int CF  = 14;
    localparam int NS  = 4;
    localparam int CAW = $clog2(5*NS);

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic signed [DW-1:0] x_in = '0;
    logic                 x_valid = 1'b0;
    logic                 x_ready;
    logic signed [DW-1:0] y_out;
    logic                 y_valid;
    logic [NS-1:0]        bypass = '0;
    logic                 flush = 1'b0;
    logic                 coef_we = 1'b0;
    logic [CAW-1:0]       coef_addr = '0;
    logic signed [CW-1:0] coef_wdata = '0;
    logic                 coef_ready;
    logic                 sat_flag;
    logic                 drop_flag;
`ifdef IIR_CASCADE_SATCNT_EN
    logic [15:0]          sat_count;
`endif

    always #5 clk = ~clk;

    iir_notch_cascade_tdm #(.DATA_WIDTH(DW), .COEF_WIDTH(CW), .COEF_FRAC(CF), .NUM_STAGES(NS)) dut (
        .clk(clk), .rst_n(rst_n), .x_in(x_in), .x_valid(x_valid), .x_ready(x_ready),
        .y_out(y_out), .y_valid(y_valid), .bypass(bypass), .flush(flush),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata), .coef_ready(coef_ready),
`ifdef IIR_CASCADE_SATCNT_EN
        .sat_count(sat_count),
`endif
        .sat_flag(sat_flag), .drop_flag(drop_flag)
    );

    int n_chk = 0;
    int n_fail = 0;
    int n_y = 0;
    int exp_q[$];
    int mc[5*NS];
    int mx1[NS], mx2[NS], my1[NS], my2[NS];
    int m_sat = 0;
    int m_drop = 0;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic void model_reset_coefs();
        for (int i = 0; i < 5*NS; i++) mc[i] = (i % 5 == 0) ? (1 << CF) : 0;
    endfunction

    function automatic void model_clear_state();
        for (int s = 0; s < NS; s++) begin
            mx1[s] = 0; mx2[s] = 0; my1[s] = 0; my2[s] = 0;
        end
    endfunction

    function automatic int model_step(input int x, input logic [NS-1:0] byp);
        longint acc, q;
        int v;
        v = x;
        for (int s = 0; s < NS; s++) begin
            if (!byp[s]) begin
                acc = longint'(mc[s*5]) * v + longint'(mc[s*5+1]) * mx1[s] + longint'(mc[s*5+2]) * mx2[s]
                    - longint'(mc[s*5+3]) * my1[s] - longint'(mc[s*5+4]) * my2[s];
                q = (acc + (64'sd1 <<< (CF-1))) >>> CF;
                if (q > 32767)       begin q = 32767;  m_sat = 1; end
                else if (q < -32768) begin q = -32768; m_sat = 1; end
                mx2[s] = mx1[s]; mx1[s] = v;
                my2[s] = my1[s]; my1[s] = int'(q);
                v = int'(q);
            end
        end
        return v;
    endfunction

    // Scoreboard: every output strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && y_valid) begin
            n_y++;
            if (exp_q.size() == 0) chk("unexpected_y_valid", 1, 0);
            else                   chk("y_out", int'($signed(y_out)), exp_q.pop_front());
        end
    end

    task automatic write_coef(input int addr, input int val);
        @(negedge clk);
        coef_we = 1'b1; coef_addr = CAW'(addr); coef_wdata = CW'(val);
        @(negedge clk);
        coef_we = 1'b0;
        mc[addr] = val;
    endtask

    task automatic issue(input int x);
        @(negedge clk);
        x_in = DW'(x); x_valid = 1'b1;
        exp_q.push_back(model_step(x, bypass));
        @(negedge clk);
        x_valid = 1'b0;
    endtask

    task automatic wait_y(output int y, output int lat);
        lat = 1;
        while (!y_valid && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 30) chk("y_valid_timeout", 0, 1);
        y = int'($signed(y_out));
        @(negedge clk);
    endtask

    task automatic send(input int x, output int y);
        int lat;
        issue(x);
        wait_y(y, lat);
        chk("latency", lat, NS+1);
    endtask

    task automatic do_flush();
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        model_clear_state();
        m_sat = 0; m_drop = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int y, lat, n0, maxabs, x;
        model_reset_coefs();
        model_clear_state();
        repeat (3) @(negedge clk);
        chk("rst_y_out", int'($signed(y_out)), 0);
        chk("rst_y_valid", int'(y_valid), 0);
        chk("rst_sat_flag", int'(sat_flag), 0);
        chk("rst_drop_flag", int'(drop_flag), 0);
        chk("rst_x_ready", int'(x_ready), 1);
        chk("rst_coef_ready", int'(coef_ready), 1);
        rst_n = 1'b1;

        send(1000, y);
        chk("passthrough_1000", y, 1000);

        write_coef(0, 8192);
        send(-3, y);
        chk("round_half_up", y, -1);
        bypass = 4'b0001;
        send(-3, y);
        chk("bypass_stage0", y, -3);
        bypass = '0;

        issue(1234);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrun_rst_y_out", int'($signed(y_out)), 0);
        chk("midrun_rst_y_valid", int'(y_valid), 0);
        exp_q.delete();
        model_reset_coefs();
        model_clear_state();
        m_sat = 0; m_drop = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrun_rst_x_ready", int'(x_ready), 1);
        send(1000, y);
        chk("post_rst_passthrough", y, 1000);

        write_coef(0, 32767);
        send(32767, y);
        chk("sat_y_out", y, 32767);
        chk("sat_flag_set", int'(sat_flag), m_sat);
`ifdef IIR_CASCADE_SATCNT_EN
        chk("sat_count_one", int'(sat_count), 1);
`endif
        do_flush();
        chk("flush_sat_flag", int'(sat_flag), 0);
        chk("flush_drop_flag", int'(drop_flag), 0);
`ifdef IIR_CASCADE_SATCNT_EN
        chk("flush_sat_count", int'(sat_count), 0);
`endif
        write_coef(0, 16384);

        n0 = n_y;
        issue(500);
        x_in = DW'(77); x_valid = 1'b1;
        coef_we = 1'b1; coef_addr = '0; coef_wdata = '0;
        m_drop = 1;
        @(negedge clk);
        x_valid = 1'b0; coef_we = 1'b0;
        wait_y(y, lat);
        repeat (6) @(negedge clk);
        chk("drop_single_y", n_y - n0, 1);
        chk("drop_y_out", y, 500);
        chk("drop_flag_set", int'(drop_flag), m_drop);
        send(600, y);
        chk("coef_we_in_run_ignored", y, 600);

        do_flush();
        write_coef(1, -21926);
        write_coef(2, 16384);
        write_coef(3, -20830);
        write_coef(4, 14787);
        maxabs = 0;
        for (int i = 0; i < 200; i++) begin
            x = $rtoi(8000.0 * $sin(2.0 * 3.14159265358979 * 2.4 / 18.0 * i));
            send(x, y);
            if (i >= 160 && (y < 0 ? -y : y) > maxabs) maxabs = (y < 0 ? -y : y);
        end
        chk("notch_residual_lt_200", int'(maxabs < 200), 1);

        write_coef(10, 12000);
        write_coef(13, -4000);
        for (int i = 0; i < 60; i++) begin
            bypass = NS'($urandom_range(0, (1 << NS) - 1));
            x = int'($urandom_range(0, 40000)) - 20000;
            send(x, y);
        end
        bypass = '0;
        chk("final_sat_flag", int'(sat_flag), m_sat);
        repeat (4) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
